// File: rtl/vm_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vm_mem_pkg: shared types and helpers for the variable-memory arbiter     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package vm_mem_pkg;

    localparam int unsigned VM_AW_DEFAULT  = 10;
    localparam int unsigned VM_DW_DEFAULT  = 32;
    localparam int unsigned VM_MAX_MASTERS = 8;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_e;

    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vm_mem_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vm_mem_arbiter_if: initiator request bus plus the shared memory port     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface vm_mem_arbiter_if
    import vm_mem_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = VM_AW_DEFAULT,
    parameter int DW          = VM_DW_DEFAULT
);
    logic [NUM_MASTERS-1:0]    req;
    logic [NUM_MASTERS-1:0]    cs;
    logic [NUM_MASTERS-1:0]    we;
    logic [NUM_MASTERS*AW-1:0] addr;
    logic [NUM_MASTERS*DW-1:0] wdata;
    logic [NUM_MASTERS-1:0]    grt;
    logic [DW-1:0]             rdata;
    logic                      busy;
    logic [2:0]                owner;
    logic                      mem_cs;
    logic                      mem_we;
    logic [AW-1:0]             mem_addr;
    logic [DW-1:0]             mem_wdata;
    logic [DW-1:0]             mem_rdata;

    modport slave (
        input  req, cs, we, addr, wdata, mem_rdata,
        output grt, rdata, busy, owner, mem_cs, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, cs, we, addr, wdata, mem_rdata,
        input  grt, rdata, busy, owner, mem_cs, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/vm_arb_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vm_arb_pick: first requester found scanning upward from start_i, wrapping|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vm_arb_pick #(
    parameter int NUM_MASTERS = 2
) (
    input  wire logic [NUM_MASTERS-1:0] req_i,
    input  wire logic [2:0]             start_i,
    output logic      [2:0]             winner_o,
    output logic                        valid_o
);
    logic [7:0] w_req_pad;
    logic [2:0] w_idx;

    assign w_req_pad = 8'(req_i);

    always_comb begin
        winner_o = 3'd0;
        valid_o  = 1'b0;
        w_idx    = 3'd0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            w_idx = 3'((int'(start_i) + k) % NUM_MASTERS);
            if (!valid_o && w_req_pad[w_idx]) begin
                valid_o  = 1'b1;
                winner_o = w_idx;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/vm_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vm_mem_arbiter: grants the shared data memory to one initiator at a time |
// | Optional VM_ARB_ROUND_ROBIN_EN rotates priority past the last owner.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vm_mem_arbiter
    import vm_mem_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = VM_AW_DEFAULT,
    parameter int DW          = VM_DW_DEFAULT
) (
    input  wire logic    Clk,
    input  wire logic    Rst,
    vm_mem_arbiter_if.slave bus
);
    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grt_q, grt_d;
    logic [2:0]             owner_q, owner_d;

    logic [7:0]    w_req_pad;
    logic [7:0]    w_cs_pad;
    logic [7:0]    w_we_pad;
    logic [AW-1:0] w_addr_arr  [8];
    logic [DW-1:0] w_wdata_arr [8];
    logic [7:0]    w_oh;
    logic [2:0]    w_start;
    logic [2:0]    w_winner;
    logic          w_valid;
    logic          w_mem_cs;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_wdata;
    logic          w_busy;

    // Pad per-master fields to 8 entries so the 3-bit owner indexes cleanly.
    assign w_req_pad = 8'(bus.req);
    assign w_cs_pad  = 8'(bus.cs);
    assign w_we_pad  = 8'(bus.we);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_unpack
            if (gi < NUM_MASTERS) begin : g_used
                assign w_addr_arr[gi]  = bus.addr[gi*AW +: AW];
                assign w_wdata_arr[gi] = bus.wdata[gi*DW +: DW];
            end else begin : g_pad
                assign w_addr_arr[gi]  = '0;
                assign w_wdata_arr[gi] = '0;
            end
        end
    endgenerate

`ifdef VM_ARB_ROUND_ROBIN_EN
    assign w_start = (owner_q == 3'(NUM_MASTERS - 1)) ? 3'd0 : owner_q + 3'd1;
`else
    assign w_start = 3'd0;
`endif

    vm_arb_pick #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_pick (
        .req_i    (bus.req),
        .start_i  (w_start),
        .winner_o (w_winner),
        .valid_o  (w_valid)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ARB_IDLE;
            grt_q   <= '0;
            owner_q <= 3'd0;
        end else begin
            state_q <= state_d;
            grt_q   <= grt_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grt_d       = grt_q;
        owner_d     = owner_q;
        w_oh        = 8'(1) << w_winner;
        w_busy      = 1'b0;
        w_mem_cs    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = w_addr_arr[owner_q];
        w_mem_wdata = w_wdata_arr[owner_q];
        case (state_q)
            ARB_IDLE: begin
                grt_d = '0;
                if (w_valid) begin
                    grt_d   = w_oh[NUM_MASTERS-1:0];
                    owner_d = onehot_to_idx(w_oh);
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                w_busy   = 1'b1;
                // A strobe arriving with the req drop belongs to no transaction.
                w_mem_cs = w_cs_pad[owner_q] & w_req_pad[owner_q];
                w_mem_we = w_mem_cs & w_we_pad[owner_q];
                if (!w_req_pad[owner_q]) begin
                    grt_d   = '0;
                    state_d = ARB_RELEASE;
                end
            end
            ARB_RELEASE: begin
                w_busy  = 1'b1;
                grt_d   = '0;
                state_d = ARB_IDLE;
            end
            default: begin
                state_d     = ARB_IDLE;
                grt_d       = '0;
                owner_d     = 3'd0;
                w_mem_addr  = '0;
                w_mem_wdata = '0;
            end
        endcase
        if (Rst) begin
            w_mem_addr  = '0;
            w_mem_wdata = '0;
        end
    end

    assign bus.grt       = grt_q;
    assign bus.owner     = owner_q;
    assign bus.busy      = w_busy;
    assign bus.mem_cs    = w_mem_cs;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.rdata     = bus.mem_rdata;
endmodule
`default_nettype wire

// File: tb/tb_vm_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vm_mem_arbiter: directed checks of grant, routing, release and reset  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_vm_mem_arbiter;
    localparam int NM = 2;
    localparam int AW = 10;
    localparam int DW = 32;

    logic Clk;
    logic Rst;
    int   checks;
    int   errors;

    logic [DW-1:0] mem [1024];

    vm_mem_arbiter_if #(.NUM_MASTERS(NM), .AW(AW), .DW(DW)) ifc ();

    vm_mem_arbiter #(.NUM_MASTERS(NM), .AW(AW), .DW(DW)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (ifc)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Synchronous single-port memory behind the arbiter.
    always @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
            mem[16]       <= 32'h1234;
            ifc.mem_rdata <= '0;
        end else if (ifc.mem_cs) begin
            if (ifc.mem_we) mem[ifc.mem_addr] <= ifc.mem_wdata;
            else            ifc.mem_rdata     <= mem[ifc.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_grt;
        checks    = 0;
        errors    = 0;
        Rst       = 1'b1;
        ifc.req   = '0;
        ifc.cs    = '0;
        ifc.we    = '0;
        ifc.addr  = {10'h000, 10'h007};
        ifc.wdata = {32'h0, 32'h77};
        tick();
        tick();
        chk("rst_grt",   64'(ifc.grt), 64'h0);
        chk("rst_busy",  64'(ifc.busy), 64'h0);
        chk("rst_owner", 64'(ifc.owner), 64'h0);
        chk("rst_cs",    64'(ifc.mem_cs), 64'h0);
        chk("rst_we",    64'(ifc.mem_we), 64'h0);
        chk("rst_addr",  64'(ifc.mem_addr), 64'h0);
        chk("rst_wdata", 64'(ifc.mem_wdata), 64'h0);
        Rst       = 1'b0;
        ifc.addr  = '0;
        ifc.wdata = '0;

        // Single master write
        ifc.req = 2'b01;
        #1 chk("t1_idle_grt", 64'(ifc.grt), 64'h0);
        tick();
        chk("t1_grt",   64'(ifc.grt), 64'h1);
        chk("t1_busy",  64'(ifc.busy), 64'h1);
        chk("t1_owner", 64'(ifc.owner), 64'h0);
        ifc.cs = 2'b01;
        ifc.we = 2'b01;
        ifc.addr[0 +: AW]  = 10'h005;
        ifc.wdata[0 +: DW] = 32'hA5;
        #1;
        chk("t1_mem_cs",    64'(ifc.mem_cs), 64'h1);
        chk("t1_mem_we",    64'(ifc.mem_we), 64'h1);
        chk("t1_mem_addr",  64'(ifc.mem_addr), 64'h5);
        chk("t1_mem_wdata", 64'(ifc.mem_wdata), 64'hA5);
        tick();
        ifc.cs  = '0;
        ifc.we  = '0;
        ifc.req = '0;
        #1 chk("t1_cs_off", 64'(ifc.mem_cs), 64'h0);
        tick();
        chk("t1_rel_grt",  64'(ifc.grt), 64'h0);
        chk("t1_rel_busy", 64'(ifc.busy), 64'h1);
        chk("t1_written",  64'(mem[5]), 64'hA5);
        tick();
        chk("t1_idle_busy", 64'(ifc.busy), 64'h0);
        chk("t1_idle_grt2", 64'(ifc.grt), 64'h0);

        // Read path
        ifc.req = 2'b01;
        tick();
        chk("t2_grt", 64'(ifc.grt), 64'h1);
        ifc.cs = 2'b01;
        ifc.we = 2'b00;
        ifc.addr[0 +: AW] = 10'h010;
        #1;
        chk("t2_mem_cs",   64'(ifc.mem_cs), 64'h1);
        chk("t2_mem_we",   64'(ifc.mem_we), 64'h0);
        chk("t2_mem_addr", 64'(ifc.mem_addr), 64'h10);
        tick();
        chk("t2_rdata", 64'(ifc.rdata), 64'h1234);
        ifc.cs = '0;

        // Isolation of a non-owner
        ifc.cs = 2'b10;
        ifc.we = 2'b10;
        ifc.addr[AW +: AW]  = 10'h3FF;
        ifc.wdata[DW +: DW] = 32'hDEADBEEF;
        #1;
        chk("t4_mem_cs",   64'(ifc.mem_cs), 64'h0);
        chk("t4_mem_we",   64'(ifc.mem_we), 64'h0);
        chk("t4_mem_addr", 64'(ifc.mem_addr), 64'h10);
        tick();
        chk("t4_no_write", 64'(mem[10'h3FF]), 64'h0);
        ifc.cs  = '0;
        ifc.we  = '0;
        ifc.req = '0;
        tick();
        tick();

        // Contention
        ifc.req = 2'b11;
        tick();
        chk("t3_grt0",   64'(ifc.grt), 64'h1);
        chk("t3_owner0", 64'(ifc.owner), 64'h0);
        ifc.req = 2'b10;
        tick();
        chk("t3_rel", 64'(ifc.grt), 64'h0);
        tick();
        chk("t3_idle", 64'(ifc.grt), 64'h0);
        tick();
        chk("t3_grt1",   64'(ifc.grt), 64'h2);
        chk("t3_owner1", 64'(ifc.owner), 64'h1);
        ifc.req = 2'b11;
        tick();
        chk("t3_hold1", 64'(ifc.grt), 64'h2);
        ifc.req = 2'b01;
        tick();
        tick();
        tick();
        chk("t3_grt0_again", 64'(ifc.grt), 64'h1);
        ifc.req = 2'b10;
        tick();
        ifc.req = 2'b11;
        tick();
        tick();
`ifdef VM_ARB_ROUND_ROBIN_EN
        exp_grt = 2'b10;
`else
        exp_grt = 2'b01;
`endif
        chk("t3_rearb", 64'(ifc.grt), 64'(exp_grt));
        ifc.req = '0;
        tick();
        tick();

        // Asynchronous reset mid-transaction
        ifc.req = 2'b01;
        tick();
        chk("t5_grt", 64'(ifc.grt), 64'h1);
        ifc.cs = 2'b01;
        #1 chk("t5_cs_on", 64'(ifc.mem_cs), 64'h1);
        #1 Rst = 1'b1;
        #1;
        chk("t5_rst_grt",  64'(ifc.grt), 64'h0);
        chk("t5_rst_cs",   64'(ifc.mem_cs), 64'h0);
        chk("t5_rst_busy", 64'(ifc.busy), 64'h0);
        #1 Rst = 1'b0;
        ifc.cs = '0;
        tick();
        chk("t5_regrant", 64'(ifc.grt), 64'h1);

        // Back-to-back re-request by the same master
        ifc.req = 2'b00;
        tick();
        chk("t6_rel_grt",  64'(ifc.grt), 64'h0);
        chk("t6_rel_busy", 64'(ifc.busy), 64'h1);
        ifc.req = 2'b01;
        tick();
        chk("t6_idle_grt",  64'(ifc.grt), 64'h0);
        chk("t6_idle_busy", 64'(ifc.busy), 64'h0);
        tick();
        chk("t6_regrant", 64'(ifc.grt), 64'h1);
        ifc.req = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vm_mem_arbiter.md
Name: vm_mem_arbiter

Overview:
- Responder end of the req/grt/cs memory-access handshake used by the variable-memory controllers.
- Accepts requests from NUM_MASTERS initiators and grants the shared data memory to exactly one of them at a time.
- Routes the owner's cs/we/addr/wdata to the memory port and broadcasts read data back.
- Grant is held for the whole multi-cycle transaction; it is released only when the owner drops req.

Parameters:
- NUM_MASTERS, 2, number of requesting initiators (2..8).
- AW, 10, memory address width in bits.
- DW, 32, data width in bits.

Ports:
- Clk  input  1  clock, rising edge.
- Rst  input  1  reset, asynchronous, active-high.
- req  input  NUM_MASTERS  per-master request; held high for the whole transaction.
- cs  input  NUM_MASTERS  per-master memory access strobe; valid only while granted.
- we  input  NUM_MASTERS  per-master write enable; qualified by cs.
- addr  input  NUM_MASTERS*AW  flattened per-master addresses; master i uses bits [i*AW +: AW].
- wdata  input  NUM_MASTERS*DW  flattened per-master write data; same packing as addr.
- grt  output  NUM_MASTERS  one-hot grant, registered.
- rdata  output  DW  read data broadcast to all masters; equals mem_rdata.
- busy  output  1  high in GRANT and RELEASE.
- owner  output  3  index of the current or last owner.
- mem_cs  output  1  memory chip select.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data; synchronous, valid one cycle after the mem_cs read.

Behaviour:
- Reset (asynchronous): state=IDLE, grt=0, owner=0, busy=0, mem_cs=0, mem_we=0, mem_addr=0, mem_wdata=0. Any grant in progress is dropped immediately.
- The FSM has three states: IDLE, GRANT, RELEASE.
- IDLE:
  - grt=0.
  - If |req, the winner is selected combinationally. On the next edge: owner<=winner, grt<=onehot(winner), state<=GRANT.
  - Latency from req rising to grt high is 1 cycle.
  - If req=0, stay in IDLE.
- GRANT:
  - mem_cs=cs[owner], mem_we=we[owner]&cs[owner], mem_addr=addr[owner], mem_wdata=wdata[owner]. These are combinational from the registered owner.
  - cs/we from non-owners are ignored.
  - If req[owner]=0 on an edge: grt<=0, state<=RELEASE.
  - Otherwise stay in GRANT; there is no timeout.
- RELEASE:
  - Lasts one cycle; grt=0, mem_cs=0, mem_we=0.
  - Next state is IDLE unconditionally. The bubble guarantees at least one dead cycle between owners.
- Outside GRANT, mem_cs=0 and mem_we=0. mem_addr and mem_wdata hold the owner's values; they are don't-care to the memory.
- rdata=mem_rdata at all times. Read latency seen by the master: cs/addr in cycle t, data valid in cycle t+1.
- Default winner selection is fixed priority: lowest index with req set wins.
- Simultaneous requests: exactly one grant is issued. The others stay pending and keep req high; they are served after RELEASE→IDLE.
- A request that rises while another master is in GRANT waits without error.
- The owner may drop req and raise it again in the very next cycle. It is then re-arbitrated in IDLE like any other master.
- cs asserted by the owner in the same edge that req drops is not forwarded.
- Invalid state encodings go to IDLE with all outputs at their reset values.

Optional Feature:
- Macro: VM_ARB_ROUND_ROBIN_EN.
- Defined: the winner search starts at (owner+1) mod NUM_MASTERS and wraps around. The last owner therefore has lowest priority on the next arbitration. owner remains valid after RELEASE for this purpose.
- Undefined: fixed lowest-index priority as above. owner still updates but does not affect selection.

Decomposition:
- Shared package vm_mem_pkg:
  - State encoding constants ARB_IDLE=2'd0, ARB_GRANT=2'd1, ARB_RELEASE=2'd2.
  - Default AW/DW constants.
  - A function for the one-hot to index conversion.
- One sub-module: vm_arb_pick, purely combinational. Inputs: req vector and start index. Outputs: winner index and valid flag. It serves both fixed and round-robin selection (start index = 0 when the macro is off).
- The FSM and the mux stay in the top level.

Test Plan:
1. Single master: req[0]=1 at cycle 0 → grt=2'b01 at cycle 1. cs[0]=1, we[0]=1, addr=10'h005, wdata=32'hA5 → mem_we=1, mem_addr=5. Drop req → grt=0 the next cycle, then one RELEASE cycle, then IDLE.
2. Read path: owner issues cs=1, we=0, addr=10'h010 while the memory holds 32'h1234 there → rdata=32'h1234 one cycle later. mem_we stays 0.
3. Contention: req=2'b11 in the same cycle → grt=2'b01. When req[0] drops → RELEASE → grt=2'b10 two cycles later. With VM_ARB_ROUND_ROBIN_EN and both masters re-requesting continuously, grants alternate 01,10,01.
4. Isolation: master 1 drives cs=1, we=1, addr=10'h3FF while master 0 owns the bus with cs=0 → mem_cs=0, mem_we=0, and no write occurs.
5. Reset mid-transaction: assert Rst while in GRANT with cs=1 → grt=0, mem_cs=0 and busy=0 immediately, without waiting for a clock edge. After Rst is released with req still high → grt reasserts after 1 cycle.
6. Back-to-back: owner drops req for one cycle and then re-raises it, with the other master idle → grt goes low for 2 cycles (RELEASE, IDLE), then the same master is granted again.
